// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage behind the 8-bit register.
// Captures one WIDTH-bit word per valid/ready handshake, then shifts it out
// one bit per shift_en cycle, framed by frame_start (first bit) and a
// one-cycle done pulse once the last bit has left.
// Optional build macro PISO_PARITY_EN appends one even-parity bit per frame
// (frame length WIDTH+1); left undefined, frames are exactly WIDTH bits.
// All outputs come straight from flops; rst is asynchronous, active low.
module piso_serializer #(
  parameter int WIDTH     = 8,    // 2..32
  parameter bit LSB_FIRST = 1'b1  // 1: din[0] first, 0: din[WIDTH-1] first
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  // counter value while the final frame bit is on sout
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
`ifdef PISO_PARITY_EN
  // counter value while the final data bit is on sout; parity follows it
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // every flop of the block in one record so reset and next-state stay aligned
  typedef struct packed {
    state_t           st;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
    logic             par;
`endif
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic             din_ready;
  } regs_t;

  regs_t            r, nx;
  logic [WIDTH-1:0] sh;

  // bit that goes on the wire next, given the current shift register image
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    lead_bit = LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // shift register image after one bit has been consumed
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    advance = LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // state and datapath register; async clear discards any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= '0;
    else      r <= nx;
  end

  // next-state / next-output decode; everything holds unless changed below
  always_comb begin
    nx = r;
    sh = advance(r.sreg);
    case (r.st)
      IDLE: begin
        nx.din_ready = 1'b1;
        // ready is the registered copy, so the first edge after reset only
        // raises din_ready and cannot capture
        if (din_valid && r.din_ready) begin
          nx.st          = SHIFT;
          nx.sreg        = din;
          nx.cnt         = '0;
`ifdef PISO_PARITY_EN
          nx.par         = ^din;
`endif
          nx.din_ready   = 1'b0;
          nx.busy        = 1'b1;
          nx.sout        = lead_bit(din);
          nx.sout_valid  = 1'b1;
          nx.frame_start = 1'b1;
        end
      end
      SHIFT: begin
        // shift_en low freezes sout, sout_valid, frame_start and cnt
        if (shift_en) begin
          nx.frame_start = 1'b0;
          if (r.cnt == LAST_BIT) begin
            nx.st         = DONE;
            nx.sout       = 1'b0;
            nx.sout_valid = 1'b0;
            nx.done       = 1'b1;
          end else begin
            nx.sreg = sh;
            nx.cnt  = r.cnt + CW'(1);
`ifdef PISO_PARITY_EN
            nx.sout = (r.cnt == LAST_DATA) ? r.par : lead_bit(sh);
`else
            nx.sout = lead_bit(sh);
`endif
          end
        end
      end
      DONE: begin
        // single-cycle done; reopen for the next word
        nx.st        = IDLE;
        nx.done      = 1'b0;
        nx.busy      = 1'b0;
        nx.din_ready = 1'b1;
      end
      default: begin
        nx.st = IDLE;
      end
    endcase
  end

  assign din_ready   = r.din_ready;
  assign sout        = r.sout;
  assign sout_valid  = r.sout_valid;
  assign frame_start = r.frame_start;
  assign busy        = r.busy;
  assign done        = r.done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer. Two instances share
// clock, reset and shift_en: u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0).
// Expected bit streams are written out by hand as wire order, MSB of the
// literal = first bit on the wire, one trailing parity bit per frame.
module tb_piso_serializer;

  logic       clk, rst, shift_en;
  logic       l_din_valid, m_din_valid;
  logic [7:0] l_din, m_din;
  logic       l_din_ready, l_sout, l_sout_valid, l_frame_start, l_busy, l_done;
  logic       m_din_ready, m_sout, m_sout_valid, m_frame_start, m_busy, m_done;

  int errors = 0;
  int checks = 0;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din_valid(l_din_valid), .din(l_din),
    .din_ready(l_din_ready), .shift_en(shift_en), .sout(l_sout),
    .sout_valid(l_sout_valid), .frame_start(l_frame_start),
    .busy(l_busy), .done(l_done));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din_valid(m_din_valid), .din(m_din),
    .din_ready(m_din_ready), .shift_en(shift_en), .sout(m_sout),
    .sout_valid(m_sout_valid), .frame_start(m_frame_start),
    .busy(m_busy), .done(m_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge (sample and drive point)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    rst = 1'b0; shift_en = 1'b0;
    l_din_valid = 1'b0; l_din = '0; m_din_valid = 1'b0; m_din = '0;
    #12;
    o = {l_din_ready, l_sout, l_sout_valid, l_frame_start, l_busy, l_done,
         m_din_ready, m_sout, m_sout_valid, m_frame_start, m_busy, m_done};
    checks++;
    if (o !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h want 000", o);
    end
    #8 rst = 1'b1;  // released at 20 ns
    tick();
    checks++;
    if (l_din_ready !== 1'b1 || m_din_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b%b want 11", l_din_ready, m_din_ready);
    end
    checks++;
    if (l_sout_valid !== 1'b0 || l_busy !== 1'b0 || m_sout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: sv=%b busy=%b msv=%b want 0 0 0",
                         l_sout_valid, l_busy, m_sout_valid);
    end
  endtask

  // 8'hF0, LSB first: 0,0,0,0,1,1,1,1 (+parity 0)
  task automatic test_lsb_frame();
    logic [8:0] seq;
    seq = 9'b0000_1111_0;
    shift_en = 1'b1; l_din = 8'hF0; l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    checks++;
    if (l_busy !== 1'b1 || l_din_ready !== 1'b0) begin
      errors++; $display("FAIL f0_capture: busy=%b ready=%b want 1 0", l_busy, l_din_ready);
    end
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (l_sout !== seq[8-i] || l_sout_valid !== 1'b1 || l_frame_start !== (i == 0)) begin
        errors++;
        $display("FAIL f0_bit%0d: sout=%b sv=%b fs=%b want %b 1 %b",
                 i, l_sout, l_sout_valid, l_frame_start, seq[8-i], (i == 0));
      end
      tick();
    end
    checks++;
    if (l_done !== 1'b1 || l_sout_valid !== 1'b0 || l_busy !== 1'b1 || l_din_ready !== 1'b0) begin
      errors++; $display("FAIL f0_done: done=%b sv=%b busy=%b ready=%b want 1 0 1 0",
                         l_done, l_sout_valid, l_busy, l_din_ready);
    end
    tick();
    checks++;
    if (l_done !== 1'b0 || l_busy !== 1'b0 || l_din_ready !== 1'b1) begin
      errors++; $display("FAIL f0_idle: done=%b busy=%b ready=%b want 0 0 1",
                         l_done, l_busy, l_din_ready);
    end
  endtask

  // 8'h11 then 8'h22, MSB first, din_valid held high throughout
  task automatic test_msb_back_to_back();
    logic [8:0] s11, s22;
    s11 = 9'b0001_0001_0;
    s22 = 9'b0010_0010_0;
    shift_en = 1'b1; m_din = 8'h11; m_din_valid = 1'b1;
    tick();
    m_din = 8'h22;  // new word waits; must not leak into the frame in flight
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (m_sout !== s11[8-i] || m_sout_valid !== 1'b1 || m_din_ready !== 1'b0) begin
        errors++; $display("FAIL h11_bit%0d: sout=%b sv=%b ready=%b want %b 1 0",
                           i, m_sout, m_sout_valid, m_din_ready, s11[8-i]);
      end
      tick();
    end
    checks++;
    if (m_done !== 1'b1 || m_sout_valid !== 1'b0) begin
      errors++; $display("FAIL h11_done: done=%b sv=%b want 1 0", m_done, m_sout_valid);
    end
    tick();
    checks++;
    if (m_din_ready !== 1'b1 || m_busy !== 1'b0 || m_sout_valid !== 1'b0) begin
      errors++; $display("FAIL h11_idle: ready=%b busy=%b sv=%b want 1 0 0",
                         m_din_ready, m_busy, m_sout_valid);
    end
    tick();
    m_din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (m_sout !== s22[8-i] || m_sout_valid !== 1'b1 || m_frame_start !== (i == 0)) begin
        errors++; $display("FAIL h22_bit%0d: sout=%b sv=%b fs=%b want %b 1 %b",
                           i, m_sout, m_sout_valid, m_frame_start, s22[8-i], (i == 0));
      end
      tick();
    end
    checks++;
    if (m_done !== 1'b1) begin
      errors++; $display("FAIL h22_done: done=%b want 1", m_done);
    end
    tick();
  endtask

  // 8'hA5, LSB first: 1,0,1,0,0,1,0,1; shift_en low 3 cycles on bit 2
  task automatic test_stall();
    logic [8:0] seq;
    seq = 9'b1010_0101_0;
    shift_en = 1'b1; l_din = 8'hA5; l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (l_sout !== seq[8-i] || l_sout_valid !== 1'b1) begin
        errors++; $display("FAIL a5_bit%0d: sout=%b sv=%b want %b 1",
                           i, l_sout, l_sout_valid, seq[8-i]);
      end
      if (i == 2) begin
        shift_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if (l_sout !== 1'b1 || l_sout_valid !== 1'b1 || l_frame_start !== 1'b0 || l_done !== 1'b0) begin
            errors++; $display("FAIL a5_stall%0d: sout=%b sv=%b fs=%b done=%b want 1 1 0 0",
                               k, l_sout, l_sout_valid, l_frame_start, l_done);
          end
        end
        shift_en = 1'b1;
      end
      tick();
    end
    checks++;
    if (l_done !== 1'b1) begin
      errors++; $display("FAIL a5_done: done=%b want 1", l_done);
    end
    tick();
  endtask

  // 8'h33 cut by reset after bit 4, then 8'h44 (0,0,1,0,0,0,1,0) runs clean
  task automatic test_reset_mid_frame();
    logic [8:0] seq;
    seq = 9'b0010_0010_0;
    shift_en = 1'b1; l_din = 8'h33; l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    repeat (4) tick();  // bit 4 now on sout
    checks++;
    if (l_sout !== 1'b1 || l_sout_valid !== 1'b1) begin
      errors++; $display("FAIL h33_bit4: sout=%b sv=%b want 1 1", l_sout, l_sout_valid);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({l_sout, l_sout_valid, l_frame_start, l_busy, l_done, l_din_ready} !== 6'b0) begin
      errors++; $display("FAIL midrst_async: got %b want 000000",
                         {l_sout, l_sout_valid, l_frame_start, l_busy, l_done, l_din_ready});
    end
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    checks++;
    if (l_done !== 1'b0 || l_busy !== 1'b0 || l_din_ready !== 1'b1 || l_sout_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_release: done=%b busy=%b ready=%b sv=%b want 0 0 1 0",
                         l_done, l_busy, l_din_ready, l_sout_valid);
    end
    l_din = 8'h44; l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (l_sout !== seq[8-i] || l_sout_valid !== 1'b1 || l_done !== 1'b0) begin
        errors++; $display("FAIL h44_bit%0d: sout=%b sv=%b done=%b want %b 1 0",
                           i, l_sout, l_sout_valid, l_done, seq[8-i]);
      end
      tick();
    end
    checks++;
    if (l_done !== 1'b1) begin
      errors++; $display("FAIL h44_done: done=%b want 1", l_done);
    end
    tick();
  endtask

`ifdef PISO_PARITY_EN
  // 8'h07, LSB first: 1,1,1,0,0,0,0,0 then parity 1
  task automatic test_parity();
    logic [8:0] seq;
    seq = 9'b1110_0000_1;
    shift_en = 1'b1; l_din = 8'h07; l_din_valid = 1'b1;
    tick();
    l_din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (l_sout !== seq[8-i] || l_sout_valid !== 1'b1 || l_done !== 1'b0) begin
        errors++; $display("FAIL par_bit%0d: sout=%b sv=%b done=%b want %b 1 0",
                           i, l_sout, l_sout_valid, l_done, seq[8-i]);
      end
      tick();
    end
    checks++;
    if (l_done !== 1'b1 || l_sout_valid !== 1'b0) begin
      errors++; $display("FAIL par_done: done=%b sv=%b want 1 0", l_done, l_sout_valid);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_frame();
    test_msb_back_to_back();
    test_stall();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
